wb_video_ctrl_v2: RTL and testbench

Parametrised second-generation Wishbone control slave for the HDMI text/pattern video path.
- Holds double-buffered (shadow/active) display state: pattern mode, cursor X/Y, vertical scroll.
- Copies shadow to active only at frame start, so updates never tear mid-frame.
- Generates cursor blink and a maskable per-frame interrupt. Sits between the Wishbone interconnect and the video timing/text renderer; all outputs go directly to the video core.

---
 rtl/wb_video_ctrl_v2_if.sv | 20 ++
 rtl/wb_video_ctrl_v2.sv | 157 +++++++++++++++
 tb/tb_wb_video_ctrl_v2.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_video_ctrl_v2_if.sv
// Wishbone slave bus bundle for the video control block.
interface wb_video_ctrl_v2_if;
  logic [7:0] wb_adr_i;
  logic [7:0] wb_dat_i;
  logic [7:0] wb_dat_o;
  logic       wb_cyc_i;
  logic       wb_stb_i;
  logic       wb_we_i;
  logic       wb_ack_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_cyc_i, wb_stb_i, wb_we_i,
    output wb_dat_o, wb_ack_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_cyc_i, wb_stb_i, wb_we_i,
    input  wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_video_ctrl_v2.sv
// Wishbone control slave for the video path: shadow/active display state committed at frame start,
// cursor blink and per-frame interrupt. Optional macro VIDEO_CTRL_AUTOCOMMIT_EN enables CTRL bit3 autocommit.
module wb_video_ctrl_v2 #(
  parameter logic [7:0] BASE_ADDR    = 8'h10,
  parameter int         COLS         = 80,
  parameter int         ROWS         = 30,
  parameter int         BLINK_FRAMES = 30,
  parameter logic [7:0] VERSION      = 8'h03
) (
  input  logic                     clk,
  input  logic                     rst_n,
  wb_video_ctrl_v2_if.slave        wb,
  input  logic                     frame_start_i,
  input  logic                     vblank_i,
  output logic [1:0]               pattern_mode_o,
  output logic [7:0]               cursor_x_o,
  output logic [7:0]               cursor_y_o,
  output logic [7:0]               scroll_y_o,
  output logic                     cursor_vis_o,
  output logic                     irq_o
);

`ifdef VIDEO_CTRL_AUTOCOMMIT_EN
  localparam logic [7:0] CTRL_MASK = 8'h0F;
`else
  localparam logic [7:0] CTRL_MASK = 8'h07;
`endif

  function automatic logic [7:0] clamp_lim(input logic [7:0] v, input int lim);
    return (int'(v) >= lim) ? 8'(lim - 1) : v;
  endfunction

  logic       ack_q;
  logic [7:0] dat_q;
  logic [1:0] sh_mode_q, ac_mode_q;
  logic [7:0] sh_x_q, sh_y_q, sh_scroll_q;
  logic [7:0] ac_x_q, ac_y_q, ac_scroll_q;
  logic [7:0] ctrl_q;
  logic [7:0] bcnt_q;
  logic       phase_q;
  logic [7:0] fcnt_q;
  logic       irq_q;
  logic       cp_q;

  logic       acc, wr;
  logic [3:0] off;
  logic [7:0] wdat, rd_data;
  logic       wr_mode, wr_x, wr_y, wr_scroll, wr_ctrl, wr_status, wr_commit;
  logic       autocommit, arm, blink_en_nxt;
  logic       unused_ok;

  // Upper address bits are decoded by the interconnect.
  assign unused_ok = ^{wb.wb_adr_i[7:4], BASE_ADDR};

  assign acc  = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
  assign wr   = acc & wb.wb_we_i;
  assign off  = wb.wb_adr_i[3:0];
  assign wdat = wb.wb_dat_i;

  assign wr_mode   = wr && (off == 4'h0);
  assign wr_x      = wr && (off == 4'h2);
  assign wr_y      = wr && (off == 4'h3);
  assign wr_scroll = wr && (off == 4'h4);
  assign wr_ctrl   = wr && (off == 4'h5);
  assign wr_status = wr && (off == 4'h6);
  assign wr_commit = wr && (off == 4'h7);

`ifdef VIDEO_CTRL_AUTOCOMMIT_EN
  assign autocommit = ctrl_q[3];
`else
  assign autocommit = 1'b0;
`endif

  assign arm = wr_commit | (autocommit & (wr_mode | wr_x | wr_y | wr_scroll));

  // A CTRL write takes effect on the blink logic in the same cycle it lands.
  assign blink_en_nxt = wr_ctrl ? wdat[1] : ctrl_q[1];

  always_comb begin
    rd_data = 8'h00;
    case (off)
      4'h0:    rd_data = {cp_q, 5'b0, sh_mode_q};
      4'h1:    rd_data = VERSION;
      4'h2:    rd_data = sh_x_q;
      4'h3:    rd_data = sh_y_q;
      4'h4:    rd_data = sh_scroll_q;
      4'h5:    rd_data = ctrl_q;
      4'h6:    rd_data = {5'b0, cp_q, vblank_i, irq_q};
      4'h8:    rd_data = fcnt_q;
      default: rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q       <= 1'b0;
      dat_q       <= 8'h00;
      sh_mode_q   <= 2'd3;
      ac_mode_q   <= 2'd3;
      sh_x_q      <= 8'h00;
      sh_y_q      <= 8'h00;
      sh_scroll_q <= 8'h00;
      ac_x_q      <= 8'h00;
      ac_y_q      <= 8'h00;
      ac_scroll_q <= 8'h00;
      ctrl_q      <= 8'h03;
      bcnt_q      <= 8'h00;
      phase_q     <= 1'b1;
      fcnt_q      <= 8'h00;
      irq_q       <= 1'b0;
      cp_q        <= 1'b0;
    end else begin
      ack_q <= acc;
      if (acc) dat_q <= rd_data;

      if (wr_mode)   sh_mode_q   <= wdat[1:0];
      if (wr_x)      sh_x_q      <= clamp_lim(wdat, COLS);
      if (wr_y)      sh_y_q      <= clamp_lim(wdat, ROWS);
      if (wr_scroll) sh_scroll_q <= clamp_lim(wdat, ROWS);
      if (wr_ctrl)   ctrl_q      <= wdat & CTRL_MASK;

      // Active state only moves at a frame boundary, using pre-write shadow values.
      if (frame_start_i && cp_q) begin
        ac_mode_q   <= sh_mode_q;
        ac_x_q      <= sh_x_q;
        ac_y_q      <= sh_y_q;
        ac_scroll_q <= sh_scroll_q;
      end
      cp_q  <= arm | (cp_q & ~frame_start_i);
      irq_q <= frame_start_i | (irq_q & ~(wr_status & wdat[0]));

      if (frame_start_i) fcnt_q <= fcnt_q + 8'd1;

      if (!blink_en_nxt) begin
        bcnt_q  <= 8'h00;
        phase_q <= 1'b1;
      end else if (frame_start_i) begin
        if (bcnt_q == 8'(BLINK_FRAMES - 1)) begin
          bcnt_q  <= 8'h00;
          phase_q <= ~phase_q;
        end else begin
          bcnt_q <= bcnt_q + 8'd1;
        end
      end
    end
  end

  assign wb.wb_ack_o    = ack_q;
  assign wb.wb_dat_o    = dat_q;
  assign pattern_mode_o = ac_mode_q;
  assign cursor_x_o     = ac_x_q;
  assign cursor_y_o     = ac_y_q;
  assign scroll_y_o     = ac_scroll_q;
  assign cursor_vis_o   = ctrl_q[0] & phase_q;
  assign irq_o          = irq_q & ctrl_q[2];

endmodule

// File: tb/tb_wb_video_ctrl_v2.sv
// Randomised scoreboard bench for wb_video_ctrl_v2 against a frame-level behavioural model.
module tb_wb_video_ctrl_v2;
  localparam int BF   = 2;
  localparam int COLS = 80;
  localparam int ROWS = 30;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_start = 1'b0;
  logic       vblank = 1'b0;
  logic [1:0] pattern_mode;
  logic [7:0] cursor_x, cursor_y, scroll_y;
  logic       cursor_vis, irq;

  wb_video_ctrl_v2_if bus();

  wb_video_ctrl_v2 #(
    .BASE_ADDR(8'h10), .COLS(COLS), .ROWS(ROWS), .BLINK_FRAMES(BF), .VERSION(8'h03)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wb(bus),
    .frame_start_i(frame_start), .vblank_i(vblank),
    .pattern_mode_o(pattern_mode), .cursor_x_o(cursor_x), .cursor_y_o(cursor_y),
    .scroll_y_o(scroll_y), .cursor_vis_o(cursor_vis), .irq_o(irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit         is_read;
    logic [3:0] off;
    logic [7:0] exp;
  } exp_t;
  exp_t sb[$];

  // Behavioural model state
  logic [1:0] m_sh_mode, m_ac_mode;
  logic [7:0] m_sh[3];
  logic [7:0] m_ac[3];
  logic [7:0] m_ctrl;
  bit         m_cp, m_irq;
  logic [7:0] m_fcnt;
  int         m_blink_n;

`ifdef VIDEO_CTRL_AUTOCOMMIT_EN
  localparam logic [7:0] M_CTRL_MASK = 8'h0F;
`else
  localparam logic [7:0] M_CTRL_MASK = 8'h07;
`endif

  function void check(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  function void m_reset();
    m_sh_mode = 2'd3; m_ac_mode = 2'd3;
    for (int i = 0; i < 3; i++) begin m_sh[i] = 8'h00; m_ac[i] = 8'h00; end
    m_ctrl = 8'h03; m_cp = 0; m_irq = 0; m_fcnt = 8'h00; m_blink_n = 0;
  endfunction

  function logic [7:0] m_min(logic [7:0] v, int n);
    int lim;
    lim = n - 1;
    return (int'(v) > lim) ? 8'(lim) : v;
  endfunction

  function void m_frame();
    m_fcnt = m_fcnt + 8'd1;
    if (m_cp) begin
      m_ac_mode = m_sh_mode;
      for (int i = 0; i < 3; i++) m_ac[i] = m_sh[i];
      m_cp = 0;
    end
    m_irq = 1;
    if (m_ctrl[1]) m_blink_n++;
  endfunction

  function void m_write(logic [3:0] off, logic [7:0] d);
    case (off)
      4'h0: m_sh_mode = d[1:0];
      4'h2: m_sh[0] = m_min(d, COLS);
      4'h3: m_sh[1] = m_min(d, ROWS);
      4'h4: m_sh[2] = m_min(d, ROWS);
      4'h5: begin
        m_ctrl = d & M_CTRL_MASK;
        if (!m_ctrl[1]) m_blink_n = 0;
      end
      4'h6: if (d[0]) m_irq = 0;
      4'h7: m_cp = 1;
      default: ;
    endcase
`ifdef VIDEO_CTRL_AUTOCOMMIT_EN
    if (m_ctrl[3] && (off == 4'h0 || off == 4'h2 || off == 4'h3 || off == 4'h4)) m_cp = 1;
`endif
  endfunction

  function logic [7:0] m_read(logic [3:0] off);
    case (off)
      4'h0: return {m_cp, 5'b0, m_sh_mode};
      4'h1: return 8'h03;
      4'h2: return m_sh[0];
      4'h3: return m_sh[1];
      4'h4: return m_sh[2];
      4'h5: return m_ctrl;
      4'h6: return {5'b0, m_cp, vblank, m_irq};
      4'h8: return m_fcnt;
      default: return 8'h00;
    endcase
  endfunction

  function bit m_vis();
    return m_ctrl[0] && (((m_blink_n / BF) % 2) == 0);
  endfunction

  task automatic chk_outs();
    check("pattern_mode", pattern_mode, m_ac_mode);
    check("cursor_x", cursor_x, m_ac[0]);
    check("cursor_y", cursor_y, m_ac[1]);
    check("scroll_y", scroll_y, m_ac[2]);
    check("cursor_vis", cursor_vis, m_vis());
    check("irq", irq, m_irq && m_ctrl[2]);
  endtask

  task automatic bus_op(input bit we, input logic [3:0] off, input logic [7:0] d, input bit with_frame);
    exp_t e;
    logic [3:0] hi;
    hi = 4'($urandom);
    @(posedge clk); #1;
    bus.wb_adr_i = {hi, off};
    bus.wb_dat_i = d;
    bus.wb_we_i  = we;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    frame_start  = with_frame;
    e.is_read = !we; e.off = off; e.exp = m_read(off);
    sb.push_back(e);
    @(posedge clk); #1;
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    frame_start  = 1'b0;
    check("ack_raised", bus.wb_ack_o, 1);
    if (with_frame && we && off == 4'h5) begin
      m_write(off, d); m_frame();
    end else begin
      if (with_frame) m_frame();
      if (we) m_write(off, d);
    end
    if (with_frame) m_irq = 1;
  endtask

  task automatic frame_pulse();
    @(posedge clk); #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    m_frame();
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_reset();
  endtask

  // Scoreboard monitor: every ack retires one issued transaction.
  always @(negedge clk) begin
    if (rst_n && bus.wb_ack_o) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_ack: got ack with empty queue at %0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.is_read) check($sformatf("read_off%0h", e.off), bus.wb_dat_o, e.exp);
      end
    end
  end

  initial begin
    bit vis_seq[5];
    vis_seq = '{1, 1, 0, 0, 1};
    bus.wb_adr_i = 8'h00; bus.wb_dat_i = 8'h00;
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    check("rst_ack", bus.wb_ack_o, 0);
    check("rst_dat", bus.wb_dat_o, 0);
    check("rst_mode_const", pattern_mode, 3);
    check("rst_vis_const", cursor_vis, 1);
    check("rst_irq_const", irq, 0);
    chk_outs();
    bus_op(0, 4'h0, 8'h00, 0);
    bus_op(0, 4'h1, 8'h00, 0);
    bus_op(0, 4'h5, 8'h00, 0);

    // Shadow not applied without commit
    bus_op(1, 4'h0, 8'h01, 0);
    frame_pulse(); frame_pulse();
    check("mode_no_commit", pattern_mode, 3);
    bus_op(1, 4'h7, 8'h00, 0);
    frame_pulse();
    check("mode_committed", pattern_mode, 1);
    chk_outs();
    bus_op(0, 4'h0, 8'h00, 0);

    // Clamping
    bus_op(1, 4'h2, 8'd200, 0);
    bus_op(1, 4'h3, 8'd45, 0);
    bus_op(1, 4'h7, 8'h00, 0);
    frame_pulse();
    check("cursor_x_clamp", cursor_x, 79);
    check("cursor_y_clamp", cursor_y, 29);
    chk_outs();

    // COMMIT coincident with frame_start
    bus_op(1, 4'h0, 8'h02, 0);
    bus_op(1, 4'h7, 8'h00, 1);
    check("commit_same_cycle", pattern_mode, 1);
    bus_op(0, 4'h6, 8'h00, 0);
    frame_pulse();
    check("commit_next_frame", pattern_mode, 2);
    bus_op(0, 4'h6, 8'h00, 0);
    chk_outs();

    // Blink sequence
    bus_op(1, 4'h5, 8'h01, 0);
    bus_op(1, 4'h5, 8'h03, 0);
    check("blink0", cursor_vis, vis_seq[0]);
    for (int i = 1; i < 5; i++) begin
      frame_pulse();
      check($sformatf("blink%0d", i), cursor_vis, vis_seq[i]);
      chk_outs();
    end
    frame_pulse();
    bus_op(1, 4'h5, 8'h01, 0);
    @(posedge clk); #1;
    check("blink_off_vis", cursor_vis, 1);

    // IRQ set-wins and clear
    bus_op(1, 4'h5, 8'h07, 0);
    frame_pulse();
    check("irq_set", irq, 1);
    bus_op(1, 4'h6, 8'h01, 1);
    check("irq_set_wins", irq, 1);
    bus_op(1, 4'h6, 8'h01, 0);
    check("irq_cleared", irq, 0);
    chk_outs();

    // Frame counter wrap
    do_reset();
    for (int i = 0; i < 256; i++) frame_pulse();
    bus_op(0, 4'h8, 8'h00, 0);
    chk_outs();

    // Randomised traffic
    for (int it = 0; it < 400; it++) begin
      int r;
      r = $urandom_range(9, 0);
      if (r <= 3)      bus_op(1, 4'($urandom), 8'($urandom), 0);
      else if (r <= 5) bus_op(0, 4'($urandom), 8'h00, 0);
      else if (r <= 7) frame_pulse();
      else if (r == 8) bus_op(1, 4'($urandom), 8'($urandom), 1);
      else begin
        @(posedge clk); #1 vblank = ~vblank;
      end
      chk_outs();
    end

    // Reset during an in-flight access drops the ack
    bus_op(1, 4'h0, 8'h00, 0);
    bus_op(1, 4'h7, 8'h00, 0);
    frame_pulse();
    @(posedge clk); #1;
    bus.wb_adr_i = 8'h11; bus.wb_we_i = 1'b0;
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_ack", bus.wb_ack_o, 0);
    check("midrst_dat", bus.wb_dat_o, 0);
    m_reset();
    chk_outs();
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
    rst_n = 1'b1;
    bus_op(0, 4'h5, 8'h00, 0);

    repeat (3) @(posedge clk);
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
